// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl - time-multiplexed scan controller for a shared BCD-to-7-seg decoder.
//
// Steps through NUM_DIGITS digits. Each slot is BLANK_CYCLES dark cycles
// (the decoder input is already set up) followed by REFRESH_DIV lit cycles.
// New values are loaded through a pending register and only reach the
// display at a frame boundary, so a frame never mixes old and new data.
//
// Ports:
//   clk, rst_n   clock, async active-low reset
//   enable       1 = scan, 0 = all digits dark (returns to IDLE)
//   load/bcd_in  single-cycle load of a new packed BCD word (nibble k = digit k)
//   lz_suppress  blank leading zeros (digit 0 is never suppressed)
//   bcd_out      nibble for the shared decoder
//   blank        decoder output must be ignored
//   digit_en     one-hot digit select
//   scan_idx     current digit index
//   frame_done   one-cycle pulse at the start of each new frame
//   load_pend    a loaded value is waiting for the frame boundary
//   bcd_err      lit digit holds a code > 9
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 1000,
  parameter int BLANK_CYCLES = 2,
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    lz_suppress,
  output logic [3:0]              bcd_out,
  output logic                    blank,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic [IW-1:0]           scan_idx,
  output logic                    frame_done,
  output logic                    load_pend,
  output logic                    bcd_err
);

  localparam int CMAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  // After a lit slot: a dark gap, or straight to the next digit when there is no gap.
  localparam state_t AFTER_SHOW = (BLANK_CYCLES == 0) ? SHOW : BLANK;

  state_t                  state, st_n;
  logic [CW-1:0]           cnt, cnt_n;
  logic [IW-1:0]           idx_n;
  logic                    fd_n;
  logic [4*NUM_DIGITS-1:0] disp, pend, disp_nxt, pend_nxt;
  logic                    lp_nxt;
  logic [1:0]              flags;   // {err, blank} for the digit about to be shown

  // {code > 9, digit must be dark}
  function automatic logic [1:0] slot_flags(input logic [4*NUM_DIGITS-1:0] d,
                                            input logic [IW-1:0] i,
                                            input logic lz);
    logic hz;
    logic err;
    hz = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++)
      if (k >= int'(i) && d[4*k +: 4] != 4'd0) hz = 1'b0;
    err = d[4*int'(i) +: 4] > 4'd9;
    return {err, err | (lz & hz & (i != '0))};
  endfunction

  // Next scan position
  always_comb begin
    st_n  = state;
    idx_n = scan_idx;
    cnt_n = cnt + 1'b1;
    fd_n  = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        idx_n = '0;
        st_n  = (BLANK_CYCLES == 0) ? SHOW : BLANK;
      end
      BLANK: if (cnt == BLANK_LAST) begin
        st_n  = SHOW;
        cnt_n = '0;
      end
      SHOW: if (cnt == SHOW_LAST) begin
        st_n  = AFTER_SHOW;
        cnt_n = '0;
        if (scan_idx == IDX_LAST) begin
          idx_n = '0;
          fd_n  = 1'b1;
        end else begin
          idx_n = scan_idx + 1'b1;
        end
      end
      default: st_n = IDLE;
    endcase
    if (!enable) begin
      st_n  = IDLE;
      idx_n = '0;
      cnt_n = '0;
      fd_n  = 1'b0;
    end
  end

  // Load handshake: display only changes while idle or at a frame boundary
  // (fd_n). A load coinciding with that moment bypasses the pending register.
  always_comb begin
    disp_nxt = disp;
    pend_nxt = pend;
    lp_nxt   = load_pend;
    if (state == IDLE || fd_n) begin
      if (load)           disp_nxt = bcd_in;
      else if (load_pend) disp_nxt = pend;
      lp_nxt = 1'b0;
    end else if (load) begin
      pend_nxt = bcd_in;
      lp_nxt   = 1'b1;
    end
  end

  assign flags = slot_flags(disp_nxt, idx_n, lz_suppress);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      scan_idx   <= '0;
      disp       <= '0;
      pend       <= '0;
      load_pend  <= 1'b0;
      frame_done <= 1'b0;
      bcd_out    <= 4'd0;
      blank      <= 1'b1;
      digit_en   <= '0;
      bcd_err    <= 1'b0;
    end else begin
      state      <= st_n;
      cnt        <= cnt_n;
      scan_idx   <= idx_n;
      disp       <= disp_nxt;
      pend       <= pend_nxt;
      load_pend  <= lp_nxt;
      frame_done <= fd_n;
      // bcd_out is valid during BLANK too so the decoder settles before the digit lights.
      bcd_out    <= (st_n == IDLE) ? 4'd0 : disp_nxt[4*int'(idx_n) +: 4];
      blank      <= (st_n == SHOW) ? flags[0] : 1'b1;
      bcd_err    <= (st_n == SHOW) & flags[1];
      digit_en   <= (st_n == SHOW) ? (NUM_DIGITS'(1) << idx_n) : '0;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with 4 digits, 4 lit cycles, 1 gap cycle
// (slot = 5 cycles, frame = 20 cycles).
module tb_seg_scan_ctrl;
  logic        clk = 1'b0;
  logic        rst_n, enable, load, lz_suppress;
  logic [15:0] bcd_in;
  logic [3:0]  bcd_out;
  logic        blank, frame_done, load_pend, bcd_err;
  logic [3:0]  digit_en;
  logic [1:0]  scan_idx;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .bcd_in(bcd_in),
    .lz_suppress(lz_suppress), .bcd_out(bcd_out), .blank(blank),
    .digit_en(digit_en), .scan_idx(scan_idx), .frame_done(frame_done),
    .load_pend(load_pend), .bcd_err(bcd_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock; outputs are sampled on the falling edge.
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Runs and checks one 20-cycle frame starting with digit 0's gap cycle.
  // ld_t / ld2_t: cycle index whose rising edge samples a load (-1 = none,
  // 0 = load on the frame-boundary edge itself).
  task automatic run_frame(input string nm, input logic [15:0] val,
                           input logic [3:0] bm, input logic [3:0] em,
                           input bit fd_first,
                           input int ld_t, input logic [15:0] ld_v,
                           input int ld2_t, input logic [15:0] ld2_v);
    logic [15:0] v;
    v = val;
    for (int t = 0; t < 20; t++) begin
      int d, ph;
      bit lp;
      d  = t / 5;
      ph = t % 5;
      if (t == ld_t)       begin load = 1'b1; bcd_in = ld_v;  end
      else if (t == ld2_t) begin load = 1'b1; bcd_in = ld2_v; end
      else                 load = 1'b0;
      tick();
      lp = (ld_t > 0) && (t >= ld_t);
      chk($sformatf("%s t%0d scan_idx", nm, t), 32'(scan_idx), 32'(d));
      chk($sformatf("%s t%0d digit_en", nm, t), 32'(digit_en),
          (ph == 0) ? 32'd0 : (32'd1 << d));
      chk($sformatf("%s t%0d bcd_out", nm, t), 32'(bcd_out), 32'(v[4*d +: 4]));
      chk($sformatf("%s t%0d blank", nm, t), 32'(blank), 32'((ph == 0) || bm[d]));
      chk($sformatf("%s t%0d bcd_err", nm, t), 32'(bcd_err), 32'((ph != 0) && em[d]));
      chk($sformatf("%s t%0d frame_done", nm, t), 32'(frame_done), 32'(t == 0 && fd_first));
      chk($sformatf("%s t%0d load_pend", nm, t), 32'(load_pend), 32'(lp));
    end
    load = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; load = 1'b0; bcd_in = 16'h0; lz_suppress = 1'b0;
    #23;
    chk("rst digit_en", 32'(digit_en), 32'd0);
    chk("rst blank", 32'(blank), 32'd1);
    chk("rst scan_idx", 32'(scan_idx), 32'd0);
    chk("rst bcd_out", 32'(bcd_out), 32'd0);
    chk("rst frame_done", 32'(frame_done), 32'd0);
    chk("rst load_pend", 32'(load_pend), 32'd0);
    chk("rst bcd_err", 32'(bcd_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Load while idle goes straight to the display.
    load = 1'b1; bcd_in = 16'h1234;
    tick();
    load = 1'b0;
    chk("idle load_pend", 32'(load_pend), 32'd0);
    chk("idle digit_en", 32'(digit_en), 32'd0);

    enable = 1'b1;
    run_frame("F1", 16'h1234, 4'b0000, 4'b0000, 1'b0, -1, 16'h0, -1, 16'h0);
    // Mid-frame load waits for the boundary.
    run_frame("F2", 16'h1234, 4'b0000, 4'b0000, 1'b1, 7, 16'h5678, -1, 16'h0);
    // Two loads before the boundary: last one wins.
    run_frame("F3", 16'h5678, 4'b0000, 4'b0000, 1'b1, 8, 16'h1111, 13, 16'h2222);
    run_frame("F4", 16'h2222, 4'b0000, 4'b0000, 1'b1, 10, 16'h0007, -1, 16'h0);
    lz_suppress = 1'b1;
    run_frame("F5", 16'h0007, 4'b1110, 4'b0000, 1'b1, 3, 16'h0000, -1, 16'h0);
    run_frame("F6", 16'h0000, 4'b1110, 4'b0000, 1'b1, -1, 16'h0, -1, 16'h0);
    lz_suppress = 1'b0;
    run_frame("F7", 16'h0000, 4'b0000, 4'b0000, 1'b1, 5, 16'h12A4, -1, 16'h0);
    // Invalid code in digit 1.
    run_frame("F8", 16'h12A4, 4'b0010, 4'b0010, 1'b1, -1, 16'h0, -1, 16'h0);
    // Load on the boundary edge: shown immediately, never pending.
    run_frame("F9", 16'h9876, 4'b0000, 4'b0000, 1'b1, 0, 16'h9876, -1, 16'h0);

    // Enable drop during digit 2 lit time.
    for (int t = 0; t < 12; t++) tick();
    chk("pre-drop scan_idx", 32'(scan_idx), 32'd2);
    chk("pre-drop digit_en", 32'(digit_en), 32'b0100);
    enable = 1'b0;
    for (int t = 0; t < 3; t++) begin
      tick();
      chk($sformatf("drop c%0d digit_en", t), 32'(digit_en), 32'd0);
      chk($sformatf("drop c%0d blank", t), 32'(blank), 32'd1);
      chk($sformatf("drop c%0d scan_idx", t), 32'(scan_idx), 32'd0);
      chk($sformatf("drop c%0d frame_done", t), 32'(frame_done), 32'd0);
    end
    enable = 1'b1;
    run_frame("F11", 16'h9876, 4'b0000, 4'b0000, 1'b0, -1, 16'h0, -1, 16'h0);

    // Asynchronous reset in the middle of a lit digit.
    tick(); tick();
    chk("pre-rst digit_en", 32'(digit_en), 32'b0001);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst digit_en", 32'(digit_en), 32'd0);
    chk("async rst blank", 32'(blank), 32'd1);
    chk("async rst scan_idx", 32'(scan_idx), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post-rst gap digit_en", 32'(digit_en), 32'd0);
    chk("post-rst gap blank", 32'(blank), 32'd1);
    chk("post-rst gap bcd_out", 32'(bcd_out), 32'd0);
    tick();
    chk("post-rst first digit_en", 32'(digit_en), 32'b0001);
    chk("post-rst first blank", 32'(blank), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexing scan controller that shares one combinational BCD-to-7-segment decoder across NUM_DIGITS physical digits. It holds a multi-digit BCD word and steps through the digits. For each digit it presents that digit's nibble to the shared decoder and drives a one-hot digit enable. It adds anti-ghosting blank gaps, leading-zero suppression, invalid-code blanking and a frame-synchronous load handshake. It sits between the user/datapath logic and the decoder + display pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8)
REFRESH_DIV, 1000, clock cycles each digit is lit per slot (>=1)
BLANK_CYCLES, 2, cycles with all digits off before each digit is lit (>=0; 0 = no gap)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
enable  in  1  1 = scanning; 0 = all digits dark
load  in  1  single-cycle request to accept bcd_in
bcd_in  in  4*NUM_DIGITS  new value; nibble k = digit k, digit 0 = least significant
lz_suppress  in  1  1 = blank leading zeros
bcd_out  out  4  nibble to shared decoder (the decoder's A,B,C,D = bcd_out[3:0])
blank  out  1  1 = decoder output must be ignored / segments off
digit_en  out  NUM_DIGITS  one-hot active-high digit select
scan_idx  out  clog2(NUM_DIGITS)  index of current digit
frame_done  out  1  one-cycle pulse at end of each full frame
load_pend  out  1  1 = a loaded value is waiting for a frame boundary
bcd_err  out  1  1 while the lit digit holds a code >9

Behaviour:
- All outputs registered. Reset (async, rst_n=0): state IDLE; bcd_out=0, blank=1, digit_en=0, scan_idx=0, frame_done=0, load_pend=0, bcd_err=0. Display and pending registers are cleared to 0.
- States:
  - IDLE: digit_en=0, blank=1. enable=1 -> BLANK with idx 0.
  - BLANK: BLANK_CYCLES cycles; digit_en=0, blank=1, bcd_out = nibble[idx] already valid (setup for decoder). Then -> SHOW. If BLANK_CYCLES=0, SHOW follows directly.
  - SHOW: REFRESH_DIV cycles; digit_en[idx]=1, all others 0.
    - Last cycle, idx<NUM_DIGITS-1 -> BLANK, idx+1.
    - Last cycle, idx=NUM_DIGITS-1 -> frame boundary: frame_done=1 for one cycle, idx wraps to 0, -> BLANK.
- Slot = BLANK_CYCLES+REFRESH_DIV cycles. Frame = NUM_DIGITS*slot cycles.
- enable=0 in any state: next cycle IDLE, idx=0, counters cleared, no frame_done. Re-enable restarts at digit 0.
- Load handshake:
  - load=1 captures bcd_in into the pending register and sets load_pend next cycle.
  - At a frame boundary with load_pend=1, pending is copied to the display register and load_pend clears. The new value is therefore shown from digit 0 of the next frame; a frame never mixes old and new data.
  - load while load_pend=1: pending is overwritten (latest wins).
  - load in the same cycle as the boundary: bcd_in goes straight to display and load_pend stays 0.
  - In IDLE, load updates the display register directly.
- Blanking during SHOW (blank=1, digit_en still asserted):
  - lz_suppress=1, nibble[idx]=0 and all higher nibbles 0, idx!=0. Digit 0 is never suppressed.
  - nibble[idx]>9: blank=1 and bcd_err=1 for that slot.
- Counters must not overflow: slot counter width clog2(max(REFRESH_DIV,BLANK_CYCLES)+1).

Test Plan:
(all with NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1)
- Reset/idle: rst_n=0 mid-SHOW -> immediately digit_en=0, blank=1, scan_idx=0. After release with enable=1 -> first digit_en=0001 appears 2 cycles after the first enabled edge (1 BLANK cycle).
- Scan order: load 0x1234, enable=1 -> digit_en 0001/0010/0100/1000 each lit 4 cycles with bcd_out 4,3,2,1 and a 1-cycle gap between digits. frame_done pulses every 20 cycles.
- Frame-synchronous load: load 0x5678 mid-frame -> load_pend=1, remaining digits still show 0x1234; the next frame shows 8,7,6,5 and load_pend=0. A second load before the boundary -> only the last value is displayed.
- Leading zeros: load 0x0007, lz_suppress=1 -> digits 3..1 blank=1, digit 0 shows 7. Load 0x0000 -> only digit 0 unblanked showing 0. lz_suppress=0 -> all digits unblanked.
- Invalid code: load 0x12A4 -> digit 1 slot has blank=1, bcd_err=1. Other digits normal.
- Enable drop: enable=0 during digit 2 SHOW -> next cycle IDLE, digit_en=0, no frame_done. Re-enable -> restarts at digit 0.
